// File: rtl/masked_field_cam.sv
// masked_field_cam: tagged-entry CAM with per-field masked search.
// Free slots are allocated automatically, lowest index first. Entries can be
// removed one at a time by address, or all together by a masked match.
// Every command runs through a two-state sequencer: IDLE, then one EXEC cycle.
// The storage update commits at the end of that EXEC cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command; rejects illegal or conflicting requests
// EXEC  | one cycle: write_busy=1, storage commits at the closing edge
module masked_field_cam #(
    parameter  int FIELD_COUNT = 2,
    parameter  int FIELD_WIDTH = 4,
    parameter  int DEPTH       = 16,
    localparam int DATA_WIDTH  = FIELD_COUNT * FIELD_WIDTH,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_enable,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   write_delete,
    input  logic [ADDR_WIDTH-1:0]  write_addr,
    input  logic                   delete_match,
    input  logic [DATA_WIDTH-1:0]  compare_data,
    input  logic [FIELD_COUNT-1:0] select_mask,
    output logic                   write_busy,
    output logic [ADDR_WIDTH-1:0]  alloc_addr,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_WIDTH:0]    count,
    output logic [DEPTH-1:0]       match_many,
    output logic [DEPTH-1:0]       match_single,
    output logic [ADDR_WIDTH-1:0]  match_addr,
    output logic                   match,
    output logic                   cmd_error
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_DEL  = 2'd1,
        OP_DELM = 2'd2
    } op_t;

    state_t                state;
    op_t                   op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0]      vec_q;

    logic [DEPTH-1:0]      valid;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH-1:0]      raw_match;
    logic [DEPTH-1:0]      single_nxt;
    logic [ADDR_WIDTH-1:0] maddr_nxt;
    logic [ADDR_WIDTH-1:0] free_addr;
    logic [DEPTH-1:0]      valid_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  cmd_any;
    logic                  cmd_multi;

    assign cmd_any   = write_enable | write_delete | delete_match;
    assign cmd_multi = (write_enable & write_delete) |
                       (write_enable & delete_match) |
                       (write_delete & delete_match);

    // Masked compare of every stored entry against the key; an empty mask matches nothing.
    always_comb begin
        raw_match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            raw_match[k] = valid[k] && (select_mask != '0);
            for (int f = 0; f < FIELD_COUNT; f++) begin
                if (select_mask[f] &&
                    (mem[k][f*FIELD_WIDTH +: FIELD_WIDTH] !=
                     compare_data[f*FIELD_WIDTH +: FIELD_WIDTH]))
                    raw_match[k] = 1'b0;
            end
        end
    end

    // Lowest matching entry as one-hot and as an index.
    always_comb begin
        single_nxt = raw_match & (~raw_match + {{(DEPTH-1){1'b0}}, 1'b1});
        maddr_nxt  = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (raw_match[k])
                maddr_nxt = ADDR_WIDTH'(k);
        end
    end

    // Lowest free slot; only consulted when the CAM is not full.
    always_comb begin
        free_addr = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (!valid[k])
                free_addr = ADDR_WIDTH'(k);
        end
    end

    // Valid vector after the current cycle's commit (only EXEC changes it).
    always_comb begin
        valid_nxt = valid;
        if (state == EXEC) begin
            case (op_q)
                OP_PUSH: valid_nxt[addr_q] = 1'b1;
                OP_DEL:  valid_nxt[addr_q] = 1'b0;
                OP_DELM: valid_nxt = valid & ~vec_q;
                default: valid_nxt = valid;
            endcase
        end
    end

    // Population count of the next valid vector, so occupancy flags move with it.
    always_comb begin
        count_nxt = '0;
        for (int k = 0; k < DEPTH; k++)
            count_nxt = count_nxt + {{ADDR_WIDTH{1'b0}}, valid_nxt[k]};
    end

    // Valid bits and occupancy flags, all updated on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            valid <= valid_nxt;
            count <= count_nxt;
            full  <= &valid_nxt;
            empty <= ~|valid_nxt;
        end
    end

    // Entry payload; deleted entries keep stale data but their valid bit hides them.
    always_ff @(posedge clk) begin
        if (!rst && state == EXEC && op_q == OP_PUSH)
            mem[addr_q] <= data_q;
    end

    // Registered search results, derived from one vector so they always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_many   <= '0;
            match_single <= '0;
            match_addr   <= '0;
            match        <= 1'b0;
        end else begin
            match_many   <= raw_match;
            match_single <= single_nxt;
            match_addr   <= maddr_nxt;
            match        <= |raw_match;
        end
    end

    // Command sequencer: accept or reject in IDLE, commit during the single EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= OP_PUSH;
            addr_q     <= '0;
            data_q     <= '0;
            vec_q      <= '0;
            write_busy <= 1'b0;
            cmd_error  <= 1'b0;
            alloc_addr <= '0;
        end else begin
            cmd_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_multi) begin
                        cmd_error <= 1'b1;
                    end else if (write_enable) begin
                        if (full) begin
                            cmd_error <= 1'b1;
                        end else begin
                            op_q       <= OP_PUSH;
                            addr_q     <= free_addr;
                            data_q     <= write_data;
                            state      <= EXEC;
                            write_busy <= 1'b1;
                        end
                    end else if (write_delete) begin
                        if (!valid[write_addr]) begin
                            cmd_error <= 1'b1;
                        end else begin
                            op_q       <= OP_DEL;
                            addr_q     <= write_addr;
                            state      <= EXEC;
                            write_busy <= 1'b1;
                        end
                    end else if (delete_match) begin
                        // Snapshot the matches now; later key changes must not widen the delete.
                        op_q       <= OP_DELM;
                        vec_q      <= raw_match;
                        state      <= EXEC;
                        write_busy <= 1'b1;
                    end
                end
                EXEC: begin
                    if (op_q == OP_PUSH)
                        alloc_addr <= addr_q;
                    if (cmd_any)
                        cmd_error <= 1'b1;
                    state      <= IDLE;
                    write_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    write_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_field_cam.sv
// Bench for masked_field_cam (2 fields x 4 bits, 8 entries).
// Stimulus keeps an array model of the CAM contents and queues one expected
// event per command (executed or rejected) with the contents expected after it.
// The monitor pops those events when the DUT shows write_busy or cmd_error and
// checks the search outputs every cycle against the committed contents.
module tb_masked_field_cam;
    localparam int FC = 2;
    localparam int FW = 4;
    localparam int D  = 8;
    localparam int DW = FC * FW;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_enable, write_delete, delete_match;
    logic [DW-1:0] write_data, compare_data;
    logic [AW-1:0] write_addr;
    logic [FC-1:0] select_mask;
    logic          write_busy, full, empty, match, cmd_error;
    logic [AW-1:0] alloc_addr, match_addr;
    logic [AW:0]   count;
    logic [D-1:0]  match_many, match_single;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_field_cam #(.FIELD_COUNT(FC), .FIELD_WIDTH(FW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .write_enable(write_enable), .write_data(write_data),
        .write_delete(write_delete), .write_addr(write_addr),
        .delete_match(delete_match), .compare_data(compare_data),
        .select_mask(select_mask), .write_busy(write_busy),
        .alloc_addr(alloc_addr), .full(full), .empty(empty), .count(count),
        .match_many(match_many), .match_single(match_single),
        .match_addr(match_addr), .match(match), .cmd_error(cmd_error)
    );

    typedef struct packed {
        logic          is_err;
        logic [D-1:0]  valid;
        logic [D*DW-1:0] data;
        logic [AW-1:0] alloc;
    } rec_t;

    rec_t cmd_q[$];

    // stimulus-side model (state after all issued commands)
    logic [D-1:0]    m_valid;
    logic [D*DW-1:0] m_data;
    logic [AW-1:0]   m_alloc;

    // monitor-side model (state the DUT has committed)
    logic [D-1:0]    c_valid;
    logic [D*DW-1:0] c_data;
    logic [AW-1:0]   c_alloc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] model_match(input logic [D-1:0] v, input logic [D*DW-1:0] d,
                                                 input logic [DW-1:0] key, input logic [FC-1:0] mask);
        logic [D-1:0] r;
        bit ok;
        r = '0;
        for (int k = 0; k < D; k++) begin
            ok = v[k] && (mask != 0);
            for (int f = 0; f < FC; f++)
                if (mask[f] && d[k*DW + f*FW +: FW] != key[f*FW +: FW]) ok = 0;
            r[k] = ok;
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        rec_t r;
        rec_t pend_rec;
        bit pend_commit;
        bit rst_prev;
        logic [D-1:0] pend_mm;
        logic [D-1:0] low;
        int idx;
        pend_commit = 0;
        rst_prev = 0;
        pend_mm = '0;
        c_valid = '0;
        c_data = '0;
        c_alloc = '0;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                chk("rst_count", count, 0);
                chk("rst_empty", empty, 1);
                chk("rst_full", full, 0);
                chk("rst_busy", write_busy, 0);
                chk("rst_cmd_error", cmd_error, 0);
                chk("rst_alloc_addr", alloc_addr, 0);
                chk("rst_match_many", match_many, 0);
                chk("rst_match_single", match_single, 0);
                chk("rst_match_addr", match_addr, 0);
                chk("rst_match", match, 0);
                c_valid = '0;
                c_alloc = '0;
                pend_commit = 0;
                cmd_q.delete();
            end else begin
                low = pend_mm & (~pend_mm + 1'b1);
                idx = (low == 0) ? 0 : $clog2(low);
                chk("match_many", match_many, pend_mm);
                chk("match_single", match_single, low);
                chk("match_addr", match_addr, idx);
                chk("match", match, pend_mm != 0);
                if (pend_commit) begin
                    c_valid = pend_rec.valid;
                    c_data  = pend_rec.data;
                    c_alloc = pend_rec.alloc;
                    pend_commit = 0;
                    chk("commit_count", count, $countones(c_valid));
                    chk("commit_full", full, c_valid == '1);
                    chk("commit_empty", empty, c_valid == '0);
                    chk("commit_alloc_addr", alloc_addr, c_alloc);
                end
                if (write_busy) begin
                    if (cmd_q.size() == 0) begin
                        chk("unexpected_busy", 1, 0);
                    end else begin
                        r = cmd_q.pop_front();
                        chk("event_kind_exec", r.is_err, 0);
                        pend_rec = r;
                        pend_commit = 1;
                    end
                end
                if (cmd_error) begin
                    if (cmd_q.size() == 0) begin
                        chk("unexpected_cmd_error", 1, 0);
                    end else begin
                        r = cmd_q.pop_front();
                        chk("event_kind_error", r.is_err, 1);
                        chk("error_count", count, $countones(c_valid));
                        chk("error_alloc_addr", alloc_addr, c_alloc);
                        chk("error_state_unchanged", r.valid, c_valid);
                    end
                end
            end
            rst_prev = rst;
            pend_mm = model_match(c_valid, c_data, compare_data, select_mask);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_cmd();
        write_enable = 0;
        write_delete = 0;
        delete_match = 0;
    endtask

    task automatic set_key(input logic [DW-1:0] k, input logic [FC-1:0] m);
        compare_data = k;
        select_mask  = m;
    endtask

    task automatic drive(input bit we, input bit wd, input bit dm, input logic [DW-1:0] d,
                         input logic [AW-1:0] a, input bit in_exec);
        rec_t r;
        bit err;
        int slot;
        err = 0;
        write_enable = we;
        write_delete = wd;
        delete_match = dm;
        write_data = d;
        write_addr = a;
        if (in_exec || (int'(we) + int'(wd) + int'(dm)) > 1) err = 1;
        else if (we) begin
            if (m_valid == '1) err = 1;
            else begin
                slot = 0;
                for (int k = D-1; k >= 0; k--) if (!m_valid[k]) slot = k;
                m_valid[slot] = 1'b1;
                m_data[slot*DW +: DW] = d;
                m_alloc = slot[AW-1:0];
            end
        end else if (wd) begin
            if (!m_valid[a]) err = 1;
            else m_valid[a] = 1'b0;
        end else if (dm) begin
            m_valid = m_valid & ~model_match(m_valid, m_data, compare_data, select_mask);
        end
        r.is_err = err;
        r.valid = m_valid;
        r.data = m_data;
        r.alloc = m_alloc;
        cmd_q.push_back(r);
    endtask

    task automatic cmd(input bit we, input bit wd, input bit dm, input logic [DW-1:0] d, input logic [AW-1:0] a);
        drive(we, wd, dm, d, a, 0);
        tick();
        clear_cmd();
        tick();
        tick();
    endtask

    task automatic push(input logic [DW-1:0] d);
        cmd(1, 0, 0, d, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        clear_cmd();
        m_valid = '0;
        m_alloc = '0;
        tick();
        tick();
        rst = 0;
        tick();
        tick();
    endtask

    task automatic rand_data(output logic [DW-1:0] d);
        d = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
    endtask

    initial begin : stimulus
        logic [DW-1:0] d;
        logic [2:0] pick;
        rst = 1;
        clear_cmd();
        write_data = 0;
        write_addr = 0;
        set_key(8'h00, 2'b11);
        m_valid = '0;
        m_data = '0;
        m_alloc = '0;
        tick();
        tick();
        rst = 0;
        repeat (10) tick();

        push(8'h13);
        set_key(8'h10, 2'b10);
        tick(); tick();
        set_key(8'h10, 2'b01);
        tick(); tick();

        push(8'h12);
        push(8'h22);
        push(8'h13);
        set_key(8'h13, 2'b11);
        tick(); tick();

        push(8'h31);
        push(8'h32);
        push(8'h33);
        push(8'h30);
        push(8'h21);
        delete_match = 0;
        cmd(0, 1, 0, 0, 3'd5);
        push(8'hAA);
        tick();

        do_reset();
        push(8'h13);
        push(8'h12);
        push(8'h22);
        push(8'h13);
        set_key(8'h02, 2'b01);
        tick();
        cmd(0, 0, 1, 0, 0);
        cmd(0, 1, 0, 0, 3'd1);
        cmd(1, 1, 0, 8'h44, 3'd0);
        set_key(8'h13, 2'b11);
        cmd(0, 0, 1, 0, 0);
        set_key(8'h00, 2'b00);
        cmd(0, 0, 1, 0, 0);

        drive(1, 0, 0, 8'h55, 0, 0);
        tick();
        clear_cmd();
        drive(0, 1, 0, 0, 3'd0, 1);
        tick();
        clear_cmd();
        tick(); tick();

        drive(1, 0, 0, 8'h77, 0, 0);
        tick();
        clear_cmd();
        rst = 1;
        m_valid = '0;
        m_alloc = '0;
        tick(); tick();
        rst = 0;
        tick(); tick();
        set_key(8'h77, 2'b11);
        tick(); tick();

        for (int i = 0; i < 300; i++) begin
            rand_data(d);
            set_key(d, 2'($urandom_range(0, 3)));
            pick = 3'($urandom_range(0, 7));
            rand_data(d);
            case (pick)
                3'd0, 3'd1, 3'd2: push(d);
                3'd3: cmd(0, 1, 0, 0, 3'($urandom_range(0, 7)));
                3'd4: cmd(0, 0, 1, 0, 0);
                3'd5: cmd(1, 1'($urandom_range(0, 1)), 1, d, 3'($urandom_range(0, 7)));
                3'd6: begin
                    if (m_valid != '1) begin
                        drive(1, 0, 0, d, 0, 0);
                        tick();
                        drive(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), d,
                              3'($urandom_range(0, 7)), 1);
                        tick();
                        clear_cmd();
                        tick(); tick();
                    end else begin
                        cmd(0, 1, 0, 0, 3'($urandom_range(0, 7)));
                    end
                end
                default: begin
                    if ($urandom_range(0, 9) == 0) do_reset();
                    else repeat ($urandom_range(1, 3)) tick();
                end
            endcase
        end

        repeat (4) tick();
        chk("queue_drained", cmd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
